// File: rtl/seq_pkg.sv
// Shared defaults for the step-sequence buffer, its FSM and benches.
package seq_pkg;

    localparam int SEQ_WIDTH = 8;     // bits per stored step code
    localparam int SEQ_DEPTH = 16;    // buffer entries (power of two)
    localparam int SEQ_DWELL = 1000;  // clock cycles per playback step

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/seq_buffer_dwell_timer.sv
// Dwell timer: free-running step counter that emits a one-cycle pulse every
// DWELL enabled cycles. Dropping timer_enable restarts the dwell period.
module dwell_timer #(
    parameter int DWELL = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic timer_enable,
    output logic timer
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles; pulse and wrap on the DWELL-th one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            timer <= 1'b0;
        end else if (!timer_enable) begin
            cnt   <= '0;
            timer <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            timer <= 1'b1;
        end else begin
            cnt   <= cnt + CW'(1);
            timer <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_buffer.sv
// Step-sequence FIFO with registered read port plus a dwell timer that paces
// playback. Optional sticky overflow/underflow flags are built when
// SEQ_BUFFER_ERR_FLAGS_EN is defined.
module seq_buffer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int DEPTH = SEQ_DEPTH,
    parameter int DWELL = SEQ_DWELL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic                     read_enable,
    input  logic                     timer_enable,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     timer,
    output logic [cnt_bits(DEPTH)-1:0] count
`ifdef SEQ_BUFFER_ERR_FLAGS_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             push, pop;

    // A pop frees a slot on the same edge, so a full buffer still accepts a
    // write when it is also being read.
    assign push  = write_enable && (!full || read_enable);
    assign pop   = read_enable && !empty;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Pointer, occupancy and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop) begin
                rptr     <= rptr + PW'(1);
                data_out <= mem[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left uninitialised; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= data_in;
    end

`ifdef SEQ_BUFFER_ERR_FLAGS_EN
    // Sticky error flags: dropped push and ignored pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enable && full && !read_enable) overflow <= 1'b1;
            if (read_enable && empty)                 underflow <= 1'b1;
        end
    end
`endif

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk          (clk),
        .reset        (reset),
        .timer_enable (timer_enable),
        .timer        (timer)
    );

endmodule

// File: tb/tb_seq_buffer.sv
// Bench for seq_buffer: table vectors, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_seq_buffer;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DW = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         write_enable = 1'b0;
    logic         read_enable = 1'b0;
    logic         timer_enable = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         empty, full, timer;
    logic [4:0]   count;
`ifdef SEQ_BUFFER_ERR_FLAGS_EN
    logic         overflow, underflow;
`endif

    seq_buffer #(.WIDTH(W), .DEPTH(D), .DWELL(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .timer_enable (timer_enable),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .timer        (timer),
        .count        (count)
`ifdef SEQ_BUFFER_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    int           m_run  = 0;
    bit           m_timer = 1'b0;
    bit           m_ovf = 1'b0, m_unf = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_dout  = '0;
        m_run   = 0;
        m_timer = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endfunction

    // Applies the rules to the inputs present at a rising edge.
    function automatic void model_edge();
        bit is_full  = (q.size() == D);
        bit is_empty = (q.size() == 0);
        bit do_push  = write_enable && (!is_full || read_enable);
        bit do_pop   = read_enable && !is_empty;
        if (write_enable && is_full && !read_enable) m_ovf = 1'b1;
        if (read_enable && is_empty)                 m_unf = 1'b1;
        if (do_pop)  m_dout = q.pop_front();
        if (do_push) q.push_back(data_in);
        if (timer_enable) begin
            m_run++;
            m_timer = (m_run % DW == 0);
        end else begin
            m_run   = 0;
            m_timer = 1'b0;
        end
    endfunction

    function automatic void compare_all();
        chk("count",    int'(count),    q.size());
        chk("empty",    int'(empty),    int'(q.size() == 0));
        chk("full",     int'(full),     int'(q.size() == D));
        chk("data_out", int'(data_out), int'(m_dout));
        chk("timer",    int'(timer),    int'(m_timer));
`ifdef SEQ_BUFFER_ERR_FLAGS_EN
        chk("overflow",  int'(overflow),  int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit we, input bit re, input logic [W-1:0] d);
        write_enable = we;
        read_enable  = re;
        data_in      = d;
    endtask

    typedef struct {
        bit           we;
        bit           re;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        int           cnt;
        bit           emp;
    } vec_t;

    vec_t         tbl[9];
    logic [W-1:0] orig[D];
    logic [W-1:0] exp_v;
    logic [W-1:0] held;

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        tbl[0] = '{1, 0, 8'h11, 8'h00, 1, 0};
        tbl[1] = '{1, 0, 8'h22, 8'h00, 2, 0};
        tbl[2] = '{1, 0, 8'h33, 8'h00, 3, 0};
        tbl[3] = '{0, 1, 8'h00, 8'h11, 2, 0};
        tbl[4] = '{0, 1, 8'h00, 8'h22, 1, 0};
        tbl[5] = '{0, 1, 8'h00, 8'h33, 0, 1};
        tbl[6] = '{1, 1, 8'h44, 8'h33, 1, 0};  // pop on empty, write still lands
        tbl[7] = '{1, 1, 8'h55, 8'h44, 1, 0};  // push+pop, count holds
        tbl[8] = '{0, 1, 8'h00, 8'h55, 0, 1};

        // reset state
        model_reset();
        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full),  0);
        chk("rst_dout",  int'(data_out), 0);
        chk("rst_timer", int'(timer), 0);
        @(negedge clk);
        reset = 1'b0;

        // table vectors
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].we, tbl[i].re, tbl[i].din);
            tick();
            chk($sformatf("tbl_dout[%0d]", i),  int'(data_out), int'(tbl[i].dout));
            chk($sformatf("tbl_count[%0d]", i), int'(count),    tbl[i].cnt);
            chk($sformatf("tbl_empty[%0d]", i), int'(empty),    int'(tbl[i].emp));
        end
        drive(0, 0, 0);
        tick();

        // fill, overflow attempt, drain in order
        for (int i = 0; i < D; i++) begin
            orig[i] = W'($urandom);
            drive(1, 0, orig[i]);
            tick();
        end
        drive(1, 0, 8'hFF);
        tick();
        chk("fill_full",  int'(full),  1);
        chk("fill_count", int'(count), 16);
`ifdef SEQ_BUFFER_ERR_FLAGS_EN
        chk("fill_overflow", int'(overflow), 1);
`endif
        for (int i = 0; i < D; i++) begin
            drive(0, 1, 0);
            tick();
            chk($sformatf("drain[%0d]", i), int'(data_out), int'(orig[i]));
        end
        chk("drain_empty", int'(empty), 1);

        // from full: simultaneous push 0xAA and pop
        for (int i = 0; i < D; i++) begin
            drive(1, 0, W'($urandom));
            tick();
        end
        drive(1, 1, 8'hAA);
        tick();
        chk("xchg_count", int'(count), 16);
        for (int i = 0; i < D; i++) begin
            drive(0, 1, 0);
            tick();
        end
        chk("xchg_aa_last", int'(data_out), 8'hAA);

        // from empty: simultaneous push and pop
        held = data_out;
        drive(1, 1, 8'h5A);
        tick();
        chk("empty_pp_count", int'(count), 1);
        chk("empty_pp_dout",  int'(data_out), int'(held));
        drive(0, 1, 0);
        tick();

        // wrap: interleaved push/pop pairs
        for (int i = 0; i < 40; i++) begin
            exp_v = W'($urandom);
            drive(1, 0, exp_v);
            tick();
            drive(0, 1, 0);
            tick();
            chk("wrap_data", int'(data_out), int'(exp_v));
            chk("wrap_le16", int'(count <= 5'd16), 1);
        end

        // dwell timer: 12 enabled cycles, pulses at 5 and 10
        drive(0, 0, 0);
        timer_enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("tmr12[%0d]", k), int'(timer), int'(k == 5 || k == 10));
        end
        timer_enable = 1'b0;
        tick();
        // drop at cycle 7, then re-raise
        timer_enable = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        timer_enable = 1'b0;
        tick();
        chk("tmr_dropped", int'(timer), 0);
        timer_enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("tmr_rearm[%0d]", k), int'(timer), int'(k == 5));
        end
        timer_enable = 1'b0;
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), W'($urandom));
            timer_enable = ($urandom_range(0, 9) != 0);
            tick();
        end

        // async reset with 7 entries and a live timer pulse
        drive(0, 1, 0);
        timer_enable = 1'b0;
        for (int i = 0; i < D + 1; i++) tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, W'(8'hC0 + i));
            tick();
        end
        drive(0, 1, 0);
        tick();
        drive(0, 0, 0);
        timer_enable = 1'b1;
        begin
            int guard = 0;
            while (!m_timer && guard < 2 * DW) begin
                tick();
                guard++;
            end
        end
        chk("pre_rst_count", int'(count), 7);
        chk("pre_rst_timer", int'(timer), 1);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_timer", int'(timer), 0);
        chk("async_dout",  int'(data_out), 0);
`ifdef SEQ_BUFFER_ERR_FLAGS_EN
        chk("async_overflow", int'(overflow), 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        timer_enable = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_buffer.md
SEQ_BUFFER -- requirements
Module: seq_buffer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each stored step code.
REQ-002 Parameter DEPTH, default 16: number of entries; power of two, at least 2.
REQ-003 Parameter DWELL, default 1000: clock cycles per playback step; at least 2.
REQ-004 clk  in  1: single clock; all state changes on rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 write_enable  in  1: push data_in this cycle (from FSM save path).
REQ-007 read_enable  in  1: pop the oldest entry this cycle (from FSM execute path).
REQ-008 timer_enable  in  1: run the dwell timer.
REQ-009 data_in  in  WIDTH: step code to store.
REQ-010 data_out  out  WIDTH: registered last-popped step code.
REQ-011 empty  out  1: high when count == 0.
REQ-012 full  out  1: high when count == DEPTH.
REQ-013 timer  out  1: single-cycle dwell-expired pulse.
REQ-014 count  out  $clog2(DEPTH)+1: current occupancy.

Function
REQ-015 A push SHALL occur when write_enable && (!full || read_enable): entry stored at the write pointer, pointer incremented modulo DEPTH.
REQ-016 A pop SHALL occur when read_enable && !empty: entry at the read pointer loaded into data_out on the same edge, pointer incremented modulo DEPTH; read latency is 1 cycle.
REQ-017 A push with full and no read SHALL be dropped; storage, pointers, and count unchanged.
REQ-018 A pop with empty SHALL be ignored; data_out holds its value, and a same-cycle write still pushes (no fall-through).
REQ-019 A simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-020 empty and full SHALL be decoded from the registered count, valid in the cycle after the causing edge.
REQ-021 The pointers SHALL wrap from DEPTH-1 to 0 with no data loss.
REQ-022 The dwell counter SHALL increment each cycle while timer_enable is high, and clear to 0 in the cycle after timer_enable goes low.
REQ-023 When the counter reaches DWELL-1, timer SHALL be high for exactly that one cycle and the counter SHALL return to 0, giving a period of DWELL cycles.
REQ-024 The first timer pulse SHALL occur DWELL cycles after timer_enable rises.
REQ-025 A pop SHALL NOT affect the timer; the timer SHALL NOT affect the buffer.

Reset
REQ-026 While reset is high: pointers = 0, count = 0, empty = 1, full = 0, data_out = 0, dwell counter = 0, timer = 0.
REQ-027 Reset asserted mid-operation SHALL discard all contents immediately, without waiting for a clock edge.
REQ-028 Storage array contents need not be cleared.

Configuration
REQ-029 With SEQ_BUFFER_ERR_FLAGS_EN defined, the block SHALL add outputs overflow and underflow.
REQ-030 overflow and underflow are sticky: each is set by a dropped push (REQ-017) or ignored pop (REQ-018), respectively, and cleared only by reset.
REQ-031 Without SEQ_BUFFER_ERR_FLAGS_EN, those ports and their logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-032 Default WIDTH, DEPTH, and DWELL constants SHALL live in package seq_pkg, shared with the FSM and its bench.
REQ-033 The pointer width localparam SHALL be derived from DEPTH.
REQ-034 The dwell timer SHALL be a sub-module named dwell_timer (ports clk, reset, timer_enable, timer), instantiated once.

Verification
REQ-035 Reset, then push 0x11, 0x22, 0x33, then 3 pops -> data_out 0x11, 0x22, 0x33 each one cycle after its pop; empty = 1 after the last pop.
REQ-036 Push 16 values (DEPTH = 16), then push 0xFF -> full = 1, count = 16; 0xFF is dropped; the 16 pops return the original order; overflow = 1 when the macro is defined.
REQ-037 From full, push 0xAA and pop together -> count stays 16 and 0xAA emerges 16th; from empty, push and pop together -> count = 1 and data_out unchanged.
REQ-038 Wrap test: 40 interleaved push/pop pairs with random data -> output sequence equals input sequence and count never exceeds 16.
REQ-039 DWELL = 5, timer_enable held 12 cycles -> timer pulses on cycles 5 and 10 only; drop timer_enable at cycle 7 and re-raise -> next pulse 5 cycles after the re-raise.
REQ-040 Assert reset asynchronously with count = 7 mid-timer -> count = 0, empty = 1, timer = 0, and data_out = 0 before the next clock edge.
